n_bit_mode_counter: RTL

Parametrised successor to the team's basic wrap-at-max counter, used as the period and timing engine for PWM and servo-channel logic. It adds:
- up/down direction, runtime step size and synchronous load;
- wrap, saturate and one-shot modes;
- a runtime-programmable maximum, double-buffered so that period changes apply only at a terminal event, giving glitch-free PWM frames;
- a one-cycle terminal-count pulse for frame synchronisation.

---
 rtl/n_bit_mode_counter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/n_bit_mode_counter.sv
// n_bit_mode_counter: up/down counter with wrap, saturate and one-shot modes.
// Runtime step, sync load, double-buffered max and a one-cycle terminal pulse.
//
// Ports:
//   COUNTER_CLOCK       rising-edge clock
//   COUNTER_RESET       async active-high reset
//   COUNTER_ENABLE      step qualifier
//   COUNTER_DIRECTION   0 = up, 1 = down
//   COUNTER_MODE        0 wrap, 1 saturate, 2 one-shot, 3 wrap
//   COUNTER_STEP        step amount (0 acts as 1)
//   COUNTER_LOAD        sync load strobe
//   COUNTER_LOAD_VALUE  value to load (clamped to active max)
//   COUNTER_MAX_WRITE   capture COUNTER_MAX_IN into pending max
//   COUNTER_MAX_IN      new maximum
//   COUNTER_START       set running / arm one-shot
//   COUNTER_VALUE       current count
//   COUNTER_TERMINAL    pulse in the cycle after a terminal event
//   COUNTER_RUNNING     one-shot armed/active flag
//   COUNTER_MAX_ACTIVE  maximum currently in force
module n_bit_mode_counter #(
  parameter int COUNTER_VALUE_WIDTH = 12,
  parameter int COUNTER_STEP_WIDTH  = 4,
  parameter logic [COUNTER_VALUE_WIDTH-1:0]
    COUNTER_MAX_DEFAULT = {COUNTER_VALUE_WIDTH{1'b1}}
) (
  input  logic                           COUNTER_CLOCK,
  input  logic                           COUNTER_RESET,
  input  logic                           COUNTER_ENABLE,
  input  logic                           COUNTER_DIRECTION,
  input  logic [1:0]                     COUNTER_MODE,
  input  logic [COUNTER_STEP_WIDTH-1:0]  COUNTER_STEP,
  input  logic                           COUNTER_LOAD,
  input  logic [COUNTER_VALUE_WIDTH-1:0] COUNTER_LOAD_VALUE,
  input  logic                           COUNTER_MAX_WRITE,
  input  logic [COUNTER_VALUE_WIDTH-1:0] COUNTER_MAX_IN,
  input  logic                           COUNTER_START,
  output logic [COUNTER_VALUE_WIDTH-1:0] COUNTER_VALUE,
  output logic                           COUNTER_TERMINAL,
  output logic                           COUNTER_RUNNING,
  output logic [COUNTER_VALUE_WIDTH-1:0] COUNTER_MAX_ACTIVE
);

  localparam int W = COUNTER_VALUE_WIDTH;
  localparam int S = COUNTER_STEP_WIDTH;
  localparam logic [1:0] MODE_SAT = 2'd1;
  localparam logic [1:0] MODE_ONE = 2'd2;

  logic [W-1:0] value_q, max_q, pend_q;
  logic         term_q, run_q, pflag_q, sflag_q;

  logic [W-1:0] value_d, max_d, pend_d;
  logic         term_d, run_d, pflag_d, sflag_d;

  logic         is_sat, is_one, idle_one;
  logic         step_en, at_bound, term_ev;
  logic         pend_any, do_xfer;
  logic [S-1:0] step_nz;
  logic [W:0]   step_x, sum;
  logic [W-1:0] pend_val, load_clamp;
  logic [W-1:0] up_val, dn_val, term_val;

  assign is_sat   = COUNTER_MODE == MODE_SAT;
  assign is_one   = COUNTER_MODE == MODE_ONE;
  assign idle_one = is_one && !run_q;
  assign step_en  = COUNTER_ENABLE && (!is_one || run_q);

  assign at_bound = COUNTER_DIRECTION ? (value_q == '0)
                                      : (value_q >= max_q);
  assign term_ev  = !COUNTER_LOAD && step_en && at_bound;

  assign step_nz = (COUNTER_STEP == '0) ? S'(1) : COUNTER_STEP;
  assign step_x  = (W+1)'(step_nz);
  assign sum     = {1'b0, value_q} + step_x;
  assign up_val  = (sum > {1'b0, max_q}) ? max_q : sum[W-1:0];
  assign dn_val  = (step_x > {1'b0, value_q}) ? '0
                 : value_q - step_x[W-1:0];

  // A write on a transfer edge bypasses the pending register.
  assign pend_any = COUNTER_MAX_WRITE || pflag_q;
  assign pend_val = COUNTER_MAX_WRITE ? COUNTER_MAX_IN : pend_q;
  assign do_xfer  = pend_any && (term_ev || idle_one);
  assign max_d    = do_xfer ? pend_val : max_q;
  assign pend_d   = pend_val;
  assign pflag_d  = pend_any && !do_xfer;

  assign load_clamp = (COUNTER_LOAD_VALUE > max_q) ? max_q
                    : COUNTER_LOAD_VALUE;

  // Terminal reload uses the max in force after this edge.
  always_comb begin
    term_val = COUNTER_DIRECTION ? max_d : '0;
    if (is_sat) begin
      if (COUNTER_DIRECTION)
        term_val = '0;
      else
        term_val = (value_q > max_d) ? max_d : value_q;
    end
  end

  always_comb begin
    value_d = value_q;
    run_d   = run_q;
    term_d  = 1'b0;
    sflag_d = sflag_q;
    if (COUNTER_LOAD) begin
      value_d = load_clamp;
      run_d   = 1'b0;
      sflag_d = 1'b0;
    end else begin
      if (term_ev) begin
        value_d = term_val;
        term_d  = !(is_sat && sflag_q);
        sflag_d = is_sat;
        if (is_one)
          run_d = 1'b0;
      end else if (step_en) begin
        value_d = COUNTER_DIRECTION ? dn_val : up_val;
        sflag_d = 1'b0;
      end
      if (COUNTER_START)
        run_d = 1'b1;
    end
  end

  always_ff @(posedge COUNTER_CLOCK or posedge COUNTER_RESET) begin
    if (COUNTER_RESET) begin
      value_q <= '0;
      term_q  <= 1'b0;
      run_q   <= 1'b0;
      max_q   <= COUNTER_MAX_DEFAULT;
      pend_q  <= COUNTER_MAX_DEFAULT;
      pflag_q <= 1'b0;
      sflag_q <= 1'b0;
    end else begin
      value_q <= value_d;
      term_q  <= term_d;
      run_q   <= run_d;
      max_q   <= max_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      sflag_q <= sflag_d;
    end
  end

  assign COUNTER_VALUE      = value_q;
  assign COUNTER_TERMINAL   = term_q;
  assign COUNTER_RUNNING    = run_q;
  assign COUNTER_MAX_ACTIVE = max_q;

endmodule
